// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: shares the single VGA adapter write port between the
// map, Link and enemy draw engines. Bursts are granted round-robin and each
// grant is held until the burst's last pixel or a stall timeout.
// Optional feature macro: TRANSPARENT_SKIP_EN (accepted pixels whose colour
// equals TRANSPARENT_COLOUR are consumed without being plotted).
module draw_port_arbiter #(
  parameter int N_REQ              = 3,
  parameter int X_W                = 8,
  parameter int Y_W                = 7,
  parameter int C_W                = 3,
  parameter int TIMEOUT            = 64,
  parameter int TRANSPARENT_COLOUR = 0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     pix_valid,
  input  logic [N_REQ-1:0]     pix_last,
  input  logic [N_REQ*X_W-1:0] pix_x,
  input  logic [N_REQ*Y_W-1:0] pix_y,
  input  logic [N_REQ*C_W-1:0] pix_colour,
  output logic [N_REQ-1:0]     pix_ready,
  output logic [N_REQ-1:0]     gnt,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 timeout
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef TRANSPARENT_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [C_W-1:0] SKIP_KEY = C_W'(TRANSPARENT_COLOUR);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [X_W-1:0]       vga_x_q, vga_x_d;
  logic [Y_W-1:0]       vga_y_q, vga_y_d;
  logic [C_W-1:0]       vga_colour_q, vga_colour_d;
  logic                 plot_q, plot_d;
  logic                 timeout_q, timeout_d;

  logic                 sel_valid, sel_last;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [C_W-1:0]       sel_colour;
  logic [PTR_W-1:0]     sel_next;
  logic [N_REQ-1:0]     pick_oh;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_found;

  assign pix_ready  = gnt_q;
  assign gnt        = gnt_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = plot_q;
  assign busy       = (state_q == GRANT);
  assign timeout    = timeout_q;

  // Route the granted requester's pixel; gnt_q is one-hot or zero.
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_next   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        sel_valid  = pix_valid[i];
        sel_last   = pix_last[i];
        sel_x      = pix_x[i*X_W +: X_W];
        sel_y      = pix_y[i*Y_W +: Y_W];
        sel_colour = pix_colour[i*C_W +: C_W];
        sel_next   = PTR_W'((i + 1) % N_REQ);
      end
    end
  end

  // Round-robin pick: first set request at or after rr_ptr_q, wrapping.
  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pick_idx = PTR_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!pick_found && req[pick_idx]) begin
        pick_oh[pick_idx] = 1'b1;
        pick_found        = 1'b1;
      end
    end
  end

  // Next-state logic: grant, pixel acceptance, release and stall timeout.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    plot_d       = 1'b0;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (sel_valid) begin
          // An accepted pixel always beats a coincident timeout.
          cnt_d = '0;
          if (!(SKIP_EN && (sel_colour == SKIP_KEY))) begin
            plot_d       = 1'b1;
            vga_x_d      = sel_x;
            vga_y_d      = sel_y;
            vga_colour_d = sel_colour;
          end
          if (sel_last) begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = sel_next;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
            state_d   = IDLE;
            gnt_d     = '0;
            rr_ptr_d  = sel_next;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Scoreboard bench for draw_port_arbiter: the driver predicts grants,
// plots and timeouts from the arbitration rules and queues them with the
// cycle they must appear in; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_draw_port_arbiter;
  localparam int N    = 3;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int TMO  = 8;
  localparam int TKEY = 0;

  logic            clock  = 1'b0;
  logic            resetn = 1'b1;
  logic [N-1:0]    req, pix_valid, pix_last, pix_ready, gnt;
  logic [N*XW-1:0] pix_x;
  logic [N*YW-1:0] pix_y;
  logic [N*CW-1:0] pix_colour;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot, busy, timeout;

  draw_port_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW),
                      .TIMEOUT(TMO), .TRANSPARENT_COLOUR(TKEY)) dut (
    .clock(clock), .resetn(resetn), .req(req), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .pix_ready(pix_ready), .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [XW-1:0] x; logic [YW-1:0] y; logic [CW-1:0] c; int cyc; } pix_t;
  typedef struct { int idx; int cyc; } gnt_t;

  pix_t exp_q[$];
  gnt_t gq[$];
  int   to_q[$];

  int errors = 0;
  int checks = 0;
  int rr_model = 0;
  bit req_chaos = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit plotted(input logic [CW-1:0] c);
    bit skip = 1'b0;
`ifdef TRANSPARENT_SKIP_EN
    skip = 1'b1;
`endif
    return !(skip && (c == CW'(TKEY)));
  endfunction

  // Monitor: invariants every cycle, scoreboard pops on DUT events.
  logic [N-1:0] prev_gnt = '0;
  pix_t pe;
  gnt_t ge;
  always @(negedge clock) begin
    if (resetn) begin
      chk("ready_eq_gnt", 32'(pix_ready), 32'(gnt));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        pe = exp_q.pop_front();
        chk("plot_missing", 32'(pe.x), 32'hFFFF_FFFF);
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        ge = gq.pop_front();
        chk("grant_missing", 32'(ge.idx), 32'hFFFF_FFFF);
      end
      while (to_q.size() > 0 && to_q[0] < cyc) begin
        void'(to_q.pop_front());
        chk("timeout_missing", 32'd0, 32'd1);
      end
      if (vga_plot) begin
        if (exp_q.size() == 0) chk("plot_unexpected_x", 32'(vga_x), 32'hFFFF_FFFF);
        else begin
          pe = exp_q.pop_front();
          chk("plot_xyc", 32'({vga_x, vga_y, vga_colour}), 32'({pe.x, pe.y, pe.c}));
          chk("plot_cycle", 32'(cyc), 32'(pe.cyc));
        end
      end
      if (timeout) begin
        if (to_q.size() == 0) chk("timeout_unexpected", 32'd1, 32'd0);
        else begin
          chk("timeout_cycle", 32'(cyc), 32'(to_q.pop_front()));
          chk("gnt_after_timeout", 32'(gnt), 32'd0);
        end
      end
      if (gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'(gnt), 32'd0);
        else begin
          ge = gq.pop_front();
          chk("grant_onehot", 32'(gnt), 32'(1) << ge.idx);
          chk("grant_cycle", 32'(cyc), 32'(ge.cyc));
        end
      end
      prev_gnt = gnt;
    end else begin
      prev_gnt = '0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Non-granted requesters throw random pixels (x=99) at the port.
  task automatic drive_junk(input int w);
    for (int j = 0; j < N; j++) begin
      if (j != w) begin
        pix_valid[j]           = 1'($urandom);
        pix_last[j]            = 1'($urandom);
        pix_x[j*XW +: XW]      = XW'(99);
        pix_y[j*YW +: YW]      = YW'($urandom);
        pix_colour[j*CW +: CW] = CW'($urandom);
      end
    end
  endtask

  // Present r during an IDLE cycle; returns the requester expected to win.
  task automatic start_round(input logic [N-1:0] r, output int w);
    w = pick(r, rr_model);
    gq.push_back('{idx: w, cyc: cyc + 1});
    req = r;
    drive_junk(w);
    pix_valid[w] = 1'b0;
    pix_last[w]  = 1'b0;
    tick();
  endtask

  task automatic send_pix(input int w, input logic [XW-1:0] x, input logic [YW-1:0] y,
                          input logic [CW-1:0] c, input bit last, input int gap);
    for (int g = 0; g < gap; g++) begin
      pix_valid[w] = 1'b0;
      pix_last[w]  = 1'b0;
      drive_junk(w);
      if (req_chaos) req = N'($urandom);
      tick();
    end
    pix_valid[w]           = 1'b1;
    pix_last[w]            = last;
    pix_x[w*XW +: XW]      = x;
    pix_y[w*YW +: YW]      = y;
    pix_colour[w*CW +: CW] = c;
    drive_junk(w);
    if (req_chaos) req = N'($urandom);
    if (plotted(c)) exp_q.push_back('{x: x, y: y, c: c, cyc: cyc + 1});
    if (last) rr_model = (w + 1) % N;
    tick();
    pix_valid[w] = 1'b0;
    pix_last[w]  = 1'b0;
  endtask

  task automatic apply_reset();
    req = '0;
    pix_valid = '0;
    pix_last = '0;
    @(negedge clock);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 resetn = 1'b1;
    rr_model = 0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, w2, g, n;
    logic [N-1:0] rp;
    logic [CW-1:0] tcol [3];
    req = '0; pix_valid = '0; pix_last = '0;
    pix_x = '0; pix_y = '0; pix_colour = '0;

    // Reset state while held in reset across clock edges.
    #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    @(negedge clock);
    #1 resetn = 1'b1;
    tick();

    // Single burst from requester 1: x=10..13, y=5, colour=4.
    start_round(3'b010, w);
    for (int i = 0; i < 4; i++) send_pix(w, XW'(10 + i), YW'(5), CW'(4), i == 3, 0);
    req = '0;
    @(negedge clock);
    chk("gnt_released", 32'(gnt), 32'd0);
    tick();

    // Transparent-key burst: colours 1,0,2, last on the third.
    tcol[0] = 3'd1; tcol[1] = 3'd0; tcol[2] = 3'd2;
    start_round(3'b001, w);
    for (int i = 0; i < 3; i++) send_pix(w, XW'(40 + i), YW'(7), tcol[i], i == 2, 0);
    req = '0;
    @(negedge clock);
    chk("gnt_released_tr", 32'(gnt), 32'd0);
    tick();

    // Fairness: req=111 held from reset, 2-pixel bursts, order 0,1,2,0,1.
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      start_round(3'b111, w);
      send_pix(w, XW'(20 + r), YW'(r), CW'(3), 1'b0, 0);
      send_pix(w, XW'(30 + r), YW'(r), CW'(5), 1'b1, 0);
    end
    req = '0;
    tick();

    // Timeout: requester 2 granted and silent, requester 0 waiting.
    apply_reset();
    start_round(3'b100, w);
    g = cyc;
    req = 3'b101;
    pix_valid[w] = 1'b0;
    to_q.push_back(g + TMO);
    rr_model = (w + 1) % N;
    w2 = pick(3'b101, rr_model);
    gq.push_back('{idx: w2, cyc: g + TMO + 1});
    repeat (TMO) begin
      drive_junk(w);
      tick();
    end
    tick();
    send_pix(w2, XW'(55), YW'(9), CW'(6), 1'b1, 0);
    req = '0;
    tick();

    // Asynchronous reset in the middle of a burst.
    apply_reset();
    start_round(3'b010, w);
    send_pix(w, XW'(70), YW'(1), CW'(1), 1'b0, 0);
    send_pix(w, XW'(71), YW'(1), CW'(2), 1'b0, 0);
    @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_plot", 32'(vga_plot), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    req = '0; pix_valid = '0; pix_last = '0;
    #20;
    @(negedge clock);
    #1 resetn = 1'b1;
    rr_model = 0;
    tick();
    start_round(3'b011, w);
    send_pix(w, XW'(80), YW'(2), CW'(7), 1'b1, 0);
    req = '0;
    tick();

    // Randomised bursts with mid-burst req churn and idle gaps.
    req_chaos = 1'b1;
    for (int r = 0; r < 80; r++) begin
      rp = N'($urandom_range(1, (1 << N) - 1));
      start_round(rp, w);
      n = $urandom_range(1, 4);
      for (int p = 0; p < n; p++)
        send_pix(w, XW'($urandom), YW'($urandom), CW'($urandom), p == n - 1,
                 $urandom_range(0, 3));
      req = '0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          drive_junk(-1);
          tick();
        end
      end
    end
    req_chaos = 1'b0;
    req = '0;
    pix_valid = '0;
    repeat (4) tick();

    chk("plots_drained", 32'(exp_q.size()), 32'd0);
    chk("grants_drained", 32'(gq.size()), 32'd0);
    chk("timeouts_drained", 32'(to_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
